// File: rtl/reaction_ctrl_mp.sv
// rtl/reaction_ctrl_mp.sv - multi-player reaction timer controller with random arm delay, foul detection and best time
//   clk_50M, rst_n            : clock, asynchronous active-low reset
//   clear, start, stop[]      : raw button levels, rising edge acts after 2-flop sync + edge detect
//   led, counter_flag         : GO lamp and counter encoding (00 clear, 01 stopped, 10 running)
//   error_flag, foul_mask     : false start indication and the players who fouled
//   winner                    : index of the winning or fouling player
//   result_ms, result_valid   : last reaction time and its freshness
//   timeout                   : nobody pressed within MAX_MS
//   best_ms                   : minimum valid result since reset or clear
module reaction_ctrl_mp #(
  parameter int unsigned NUM_PLAYERS   = 2,
  parameter int unsigned TICK_CYC      = 50000,
  parameter int unsigned MIN_DELAY_CYC = 100000000,
  parameter int unsigned RANGE_LOG2    = 28,
  parameter int unsigned MAX_MS        = 9999,
  parameter int unsigned RES_W         = 14
) (
  input  logic                   clk_50M,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   start,
  input  logic [NUM_PLAYERS-1:0] stop,
  output logic                   led,
  output logic [1:0]             counter_flag,
  output logic                   error_flag,
  output logic [NUM_PLAYERS-1:0] foul_mask,
  output logic [2:0]             winner,
  output logic [RES_W-1:0]       result_ms,
  output logic                   result_valid,
  output logic                   timeout,
  output logic [RES_W-1:0]       best_ms
);

  localparam int unsigned IN_W  = NUM_PLAYERS + 2;
  localparam int unsigned PRE_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
  localparam logic [RES_W-1:0] MAX_R    = RES_W'(MAX_MS);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYC - 1);
  localparam longint unsigned DELAY_SPAN = longint'(MIN_DELAY_CYC) + (64'd1 << RANGE_LOG2);

  if (DELAY_SPAN >= 64'h1_0000_0000) begin : g_bad_delay
    $error("MIN_DELAY_CYC + 2**RANGE_LOG2 does not fit the 32-bit delay counter");
  end
  if (NUM_PLAYERS < 1 || NUM_PLAYERS > 8) begin : g_bad_players
    $error("NUM_PLAYERS must be 1..8");
  end

  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_GO, S_DONE, S_FOUL} state_t;

  // Button synchronisers, packed as {clear, start, stop}
  logic [IN_W-1:0] in_s1_q, in_s2_q, in_s3_q;
  logic [IN_W-1:0] edge_w;
  logic            clear_edge, start_edge;
  logic [NUM_PLAYERS-1:0] stop_edge;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      in_s1_q <= '0;
      in_s2_q <= '0;
      in_s3_q <= '0;
    end else begin
      in_s1_q <= {clear, start, stop};
      in_s2_q <= in_s1_q;
      in_s3_q <= in_s2_q;
    end
  end

  assign edge_w     = in_s2_q & ~in_s3_q;
  assign clear_edge = edge_w[IN_W-1];
  assign start_edge = edge_w[IN_W-2];
  assign stop_edge  = edge_w[NUM_PLAYERS-1:0];

  // Galois LFSR, x^32+x^22+x^2+x+1; the feedback always sets bit 31 so it never locks at 0
  logic [31:0] lfsr_q, lfsr_d;
  assign lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? 32'h8020_0003 : 32'h0);

  function automatic logic [2:0] lowest_idx(input logic [NUM_PLAYERS-1:0] v);
    lowest_idx = '0;
    for (int i = int'(NUM_PLAYERS) - 1; i >= 0; i--) begin
      if (v[i]) lowest_idx = 3'(i);
    end
  endfunction

  state_t                 state_q;
  logic [31:0]            delay_cnt_q;
  logic [PRE_W-1:0]       presc_q;
  logic [RES_W-1:0]       ms_cnt_q;
  logic                   led_q, error_q, result_valid_q, timeout_q;
  logic [1:0]             cflag_q;
  logic [NUM_PLAYERS-1:0] foul_q;
  logic [2:0]             winner_q;
  logic [RES_W-1:0]       result_q, best_q;

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q         <= 32'h1;
      state_q        <= S_IDLE;
      delay_cnt_q    <= '0;
      presc_q        <= '0;
      ms_cnt_q       <= '0;
      led_q          <= 1'b0;
      cflag_q        <= 2'b00;
      error_q        <= 1'b0;
      foul_q         <= '0;
      winner_q       <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      timeout_q      <= 1'b0;
      best_q         <= MAX_R;
    end else begin
      lfsr_q <= lfsr_d;
      if (clear_edge) begin
        // Same as reset, but the LFSR keeps its sequence
        state_q        <= S_IDLE;
        delay_cnt_q    <= '0;
        presc_q        <= '0;
        ms_cnt_q       <= '0;
        led_q          <= 1'b0;
        cflag_q        <= 2'b00;
        error_q        <= 1'b0;
        foul_q         <= '0;
        winner_q       <= '0;
        result_q       <= '0;
        result_valid_q <= 1'b0;
        timeout_q      <= 1'b0;
        best_q         <= MAX_R;
      end else begin
        case (state_q)
          S_IDLE, S_DONE, S_FOUL: begin
            if (start_edge) begin
              state_q        <= S_ARMED;
              delay_cnt_q    <= 32'(MIN_DELAY_CYC) + 32'(lfsr_q[RANGE_LOG2-1:0]);
              led_q          <= 1'b0;
              error_q        <= 1'b0;
              foul_q         <= '0;
              result_valid_q <= 1'b0;
              timeout_q      <= 1'b0;
              cflag_q        <= 2'b00;
            end
          end
          S_ARMED: begin
            delay_cnt_q <= delay_cnt_q - 32'd1;
            if (|stop_edge) begin
              state_q  <= S_FOUL;
              foul_q   <= foul_q | stop_edge;
              winner_q <= lowest_idx(stop_edge);
              error_q  <= 1'b1;
              cflag_q  <= 2'b01;
            end else if (delay_cnt_q <= 32'd1) begin
              // <= also catches a zero load so the round cannot stall
              state_q  <= S_GO;
              led_q    <= 1'b1;
              cflag_q  <= 2'b10;
              ms_cnt_q <= '0;
              presc_q  <= '0;
            end
          end
          S_GO: begin
            if (presc_q == PRE_LAST) begin
              presc_q <= '0;
              if (ms_cnt_q != MAX_R) ms_cnt_q <= ms_cnt_q + 1'b1;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
            if (|stop_edge) begin
              state_q        <= S_DONE;
              winner_q       <= lowest_idx(stop_edge);
              result_q       <= ms_cnt_q;
              result_valid_q <= 1'b1;
              led_q          <= 1'b0;
              cflag_q        <= 2'b01;
              if (ms_cnt_q < best_q) best_q <= ms_cnt_q;
            end else if (ms_cnt_q == MAX_R) begin
              state_q   <= S_DONE;
              timeout_q <= 1'b1;
              result_q  <= MAX_R;
              led_q     <= 1'b0;
              cflag_q   <= 2'b01;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign led          = led_q;
  assign counter_flag = cflag_q;
  assign error_flag   = error_q;
  assign foul_mask    = foul_q;
  assign winner       = winner_q;
  assign result_ms    = result_q;
  assign result_valid = result_valid_q;
  assign timeout      = timeout_q;
  assign best_ms      = best_q;

endmodule

// File: tb/tb_reaction_ctrl_mp.sv
// tb/tb_reaction_ctrl_mp.sv - directed self-checking bench for reaction_ctrl_mp
module tb_reaction_ctrl_mp;

  logic       clk_50M = 1'b0;
  logic       rst_n   = 1'b0;
  logic       clear   = 1'b0;
  logic       start   = 1'b0;
  logic [2:0] stop    = 3'b000;
  logic       led;
  logic [1:0] counter_flag;
  logic       error_flag;
  logic [2:0] foul_mask;
  logic [2:0] winner;
  logic [13:0] result_ms;
  logic       result_valid;
  logic       timeout;
  logic [13:0] best_ms;

  int checks   = 0;
  int failures = 0;

  always #5 clk_50M = ~clk_50M;

  reaction_ctrl_mp #(
    .NUM_PLAYERS(3), .TICK_CYC(4), .MIN_DELAY_CYC(20),
    .RANGE_LOG2(3), .MAX_MS(50), .RES_W(14)
  ) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .clear(clear), .start(start), .stop(stop),
    .led(led), .counter_flag(counter_flag), .error_flag(error_flag),
    .foul_mask(foul_mask), .winner(winner), .result_ms(result_ms),
    .result_valid(result_valid), .timeout(timeout), .best_ms(best_ms)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start and waits for the lamp; pin-to-lamp is 3 sync cycles plus a 20..27 cycle delay
  task automatic start_wait_led(input string tag);
    int cyc = 0;
    @(posedge clk_50M); #1 start = 1'b1;
    while (led !== 1'b1 && cyc < 60) begin
      @(posedge clk_50M); #1;
      cyc++;
      if (cyc == 4) start = 1'b0;
    end
    start = 1'b0;
    chk({tag, "_led_delay_in_window"}, 32'(cyc >= 23 && cyc <= 30), 1);
    chk({tag, "_cf_running"}, 32'(counter_flag), 2);
  endtask

  // Raises stop pins n cycles after the lamp edge; the press acts 3 edges later
  task automatic press_after(input int n, input logic [2:0] bits);
    repeat (n) @(posedge clk_50M);
    #1 stop = bits;
    repeat (3) @(posedge clk_50M);
    #1;
  endtask

  task automatic release_stop();
    repeat (2) @(posedge clk_50M);
    #1 stop = 3'b000;
    repeat (4) @(posedge clk_50M);
    #1;
  endtask

  initial begin
    int n;
    logic led_seen;

    // Reset state
    repeat (3) @(posedge clk_50M);
    #1;
    chk("rst_led", 32'(led), 0);
    chk("rst_cf", 32'(counter_flag), 0);
    chk("rst_err", 32'(error_flag), 0);
    chk("rst_foul", 32'(foul_mask), 0);
    chk("rst_winner", 32'(winner), 0);
    chk("rst_result", 32'(result_ms), 0);
    chk("rst_rv", 32'(result_valid), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_best", 32'(best_ms), 50);
    rst_n = 1'b1;
    repeat (2) @(posedge clk_50M);
    #1;

    // 1 + 2: lamp timing, then player 1 after 40 cycles -> 42/4 = 10 ms
    start_wait_led("t1");
    press_after(40, 3'b010);
    chk("t2_result", 32'(result_ms), 10);
    chk("t2_winner", 32'(winner), 1);
    chk("t2_rv", 32'(result_valid), 1);
    chk("t2_best", 32'(best_ms), 10);
    chk("t2_led", 32'(led), 0);
    chk("t2_cf", 32'(counter_flag), 1);
    release_stop();

    // 3: false start by player 2 during the arm delay
    @(posedge clk_50M); #1 start = 1'b1;
    repeat (5) @(posedge clk_50M);
    #1 stop = 3'b100; start = 1'b0;
    led_seen = 1'b0;
    repeat (3) @(posedge clk_50M);
    #1;
    chk("t3_err", 32'(error_flag), 1);
    chk("t3_foul_mask", 32'(foul_mask), 3'b100);
    chk("t3_winner", 32'(winner), 2);
    chk("t3_cf", 32'(counter_flag), 1);
    chk("t3_rv", 32'(result_valid), 0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk_50M); #1;
      if (led === 1'b1) led_seen = 1'b1;
    end
    chk("t3_led_never", 32'(led_seen), 0);
    stop = 3'b000;
    repeat (4) @(posedge clk_50M);
    #1;

    // 4: simultaneous presses pick the lowest index; best keeps the minimum
    start_wait_led("t4a");
    press_after(40, 3'b101);
    chk("t4a_winner", 32'(winner), 0);
    chk("t4a_result", 32'(result_ms), 10);
    chk("t4a_best", 32'(best_ms), 10);
    release_stop();
    start_wait_led("t4b");
    press_after(24, 3'b010);
    chk("t4b_result", 32'(result_ms), 6);
    chk("t4b_best", 32'(best_ms), 6);
    release_stop();
    start_wait_led("t4c");
    press_after(36, 3'b001);
    chk("t4c_result", 32'(result_ms), 9);
    chk("t4c_winner", 32'(winner), 0);
    chk("t4c_best", 32'(best_ms), 6);
    release_stop();

    // 5: nobody presses; 50 ticks of 4 cycles, timeout seen one edge after the count saturates
    start_wait_led("t5");
    n = 0;
    while (timeout !== 1'b1 && n < 300) begin
      @(posedge clk_50M); #1;
      n++;
    end
    chk("t5_timeout_cycle", 32'(n), 201);
    chk("t5_timeout", 32'(timeout), 1);
    chk("t5_result", 32'(result_ms), 50);
    chk("t5_rv", 32'(result_valid), 0);
    chk("t5_best", 32'(best_ms), 6);
    chk("t5_led", 32'(led), 0);
    chk("t5_cf", 32'(counter_flag), 1);

    // 6a: clear during GO
    start_wait_led("t6a");
    repeat (10) @(posedge clk_50M);
    #1 clear = 1'b1;
    repeat (3) @(posedge clk_50M);
    #1;
    chk("t6a_led", 32'(led), 0);
    chk("t6a_cf", 32'(counter_flag), 0);
    chk("t6a_best", 32'(best_ms), 50);
    chk("t6a_timeout", 32'(timeout), 0);
    clear = 1'b0;
    repeat (4) @(posedge clk_50M);
    #1;

    // 6b: clear coincident with a stop edge; the stop must not register
    start_wait_led("t6b");
    repeat (8) @(posedge clk_50M);
    #1 clear = 1'b1; stop = 3'b010;
    repeat (3) @(posedge clk_50M);
    #1;
    chk("t6b_cf", 32'(counter_flag), 0);
    chk("t6b_led", 32'(led), 0);
    chk("t6b_rv", 32'(result_valid), 0);
    chk("t6b_result", 32'(result_ms), 0);
    chk("t6b_best", 32'(best_ms), 50);
    repeat (5) @(posedge clk_50M);
    #1;
    chk("t6b_cf_idle_hold", 32'(counter_flag), 0);
    clear = 1'b0; stop = 3'b000;
    repeat (4) @(posedge clk_50M);
    #1;

    // 6c: build a result, re-arm, then assert reset mid-cycle while ARMED
    start_wait_led("t6c");
    press_after(40, 3'b100);
    chk("t6c_result", 32'(result_ms), 10);
    release_stop();
    @(posedge clk_50M); #1 start = 1'b1;
    repeat (10) @(posedge clk_50M);
    #1 start = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("t6c_rst_result", 32'(result_ms), 0);
    chk("t6c_rst_best", 32'(best_ms), 50);
    chk("t6c_rst_winner", 32'(winner), 0);
    chk("t6c_rst_cf", 32'(counter_flag), 0);
    led_seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk_50M); #1;
      if (led === 1'b1) led_seen = 1'b1;
    end
    chk("t6c_rst_led_never", 32'(led_seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reaction_ctrl_mp.md
Name: reaction_ctrl_mp

Overview:
Multi-player, parametrised reaction-timer controller for the reaction-test game. It waits a pseudo-random delay after start, then lights the GO LED and times the first player to press stop, in milliseconds. It also detects per-player false starts, keeps a best-time register, and drives the existing counter/display path through counter_flag, result and error outputs.

Parameters:
NUM_PLAYERS, 2, number of stop inputs (1..8).
TICK_CYC, 50000, clk_50M cycles per 1 ms tick.
MIN_DELAY_CYC, 100000000, minimum random wait (2 s at 50 MHz).
RANGE_LOG2, 28, random span is 0..2^RANGE_LOG2-1 cycles added to MIN_DELAY_CYC.
MAX_MS, 9999, timing saturation and timeout value (4-digit display).
RES_W, 14, width of the ms result registers.

Ports:
clk_50M  in  1  system clock, 50 MHz.
rst_n  in  1  asynchronous active-low reset.
clear  in  1  level button, rising-edge acts.
start  in  1  level button, rising-edge acts.
stop  in  NUM_PLAYERS  per-player buttons, rising-edge acts.
led  out  1  GO lamp.
counter_flag  out  2  00 = clear, 01 = stopped, 10 = running (existing counter encoding).
error_flag  out  1  foul indicator (display shows F).
foul_mask  out  NUM_PLAYERS  players who false-started this round.
winner  out  3  index of the winning or fouling player.
result_ms  out  RES_W  reaction time of the last valid round.
result_valid  out  1  result_ms holds a fresh result.
timeout  out  1  no player pressed within MAX_MS.
best_ms  out  RES_W  minimum valid result since reset or clear.

Behaviour:
- Inputs are synchronised with 2 flip-flops, then edge-detected with 1 flip-flop. An edge therefore acts 3 cycles after the pin rises. All logic is registered.
- Reset: all outputs 0 except best_ms = MAX_MS. FSM = IDLE, LFSR = 32'h1, all counters 0. Reset mid-round aborts immediately.
- LFSR: 32-bit Galois, taps x^32+x^22+x^2+x+1, advances every cycle in every state and is never 0.
- States: IDLE, ARMED, GO, DONE, FOUL.
- IDLE/DONE/FOUL + start edge -> ARMED.
  - delay_cnt <= MIN_DELAY_CYC + lfsr[RANGE_LOG2-1:0].
  - led = 0, error_flag = 0, foul_mask = 0, result_valid = 0, timeout = 0, counter_flag = 00.
- ARMED: delay_cnt decrements each cycle.
  - Any stop edge -> FOUL. foul_mask |= the edges, winner = lowest set index, error_flag = 1, counter_flag = 01, led stays 0.
  - Otherwise, when delay_cnt reaches 1 -> GO on the next cycle. led = 1, counter_flag = 10, ms_cnt = 0, tick prescaler = 0.
- GO: the prescaler counts 0..TICK_CYC-1. On wrap, ms_cnt increments and saturates at MAX_MS.
  - Stop edge(s) -> DONE. winner = lowest set index, result_ms = ms_cnt (value before any same-cycle increment), result_valid = 1, led = 0, counter_flag = 01.
  - best_ms <= min(best_ms, result_ms) in the same cycle.
  - If ms_cnt reaches MAX_MS with no stop -> DONE. timeout = 1, result_ms = MAX_MS, result_valid = 0, best_ms unchanged.
- DONE/FOUL: outputs hold. Stop edges are ignored.
- A start edge in ARMED or GO is ignored.
- Clear edge has the highest priority in every state and overrides start/stop in the same cycle.
  - Effect is the same as reset except the LFSR keeps running.
  - best_ms = MAX_MS, FSM = IDLE, counter_flag = 00.
- Widths: ms_cnt and result use RES_W bits. delay_cnt is 32 bits. MIN_DELAY_CYC + 2^RANGE_LOG2 must be < 2^32, and this is checked by elaboration assertion.

Test Plan:
(Bench parameters for all scenarios: TICK_CYC=4, MIN_DELAY_CYC=20, RANGE_LOG2=3, MAX_MS=50, NUM_PLAYERS=3.)
1. Reset, then start pulse -> led rises 20..27 cycles after the synchronised start edge. counter_flag = 10 in the same cycle.
2. From case 1, stop[1] 40 cycles after led -> DONE. result_ms = 10, winner = 1, result_valid = 1, best_ms = 10, led = 0, counter_flag = 01.
3. Start, then stop[2] 5 cycles later (during ARMED) -> FOUL. error_flag = 1, foul_mask = 3'b100, winner = 2, led never rises.
4. Start, then in GO stop[0] and stop[2] rise in the same cycle -> winner = 0. Second round with result 6 -> best_ms = 6. Third round with result 9 -> best_ms stays 6.
5. Start, no stop -> after 50 ms ticks: timeout = 1, result_ms = 50, result_valid = 0, best_ms unchanged.
6. Clear pulse during GO, plus a clear edge coincident with a stop edge -> IDLE, led = 0, counter_flag = 00, best_ms = 50. Separately, rst_n low mid-ARMED -> all outputs at reset values within the same cycle.
